// File: rtl/measure_pkg.sv
// Shared FSM state encoding and default parameter values for the multi-channel
// frequency/period measurement block.
`timescale 1ns/1ps
package measure_pkg;
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GATE,
    ST_WAIT,
    ST_DUMP
  } state_t;

  localparam int DEF_CH_NUM         = 4;
  localparam int DEF_CNT_WIDTH      = 32;
  localparam int DEF_GATE_WIDTH     = 32;
  localparam int DEF_TIMEOUT_CYCLES = 65535;
endpackage

// File: rtl/measure_ch.sv
// One measurement channel: input synchronizer, rising-edge pulse, window flag
// and saturating signal/reference counters.
`timescale 1ns/1ps
module measure_ch
  import measure_pkg::*;
#(
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 sig_i,
  input  logic                 clr_i,
  input  logic                 gate_i,
  input  logic                 wait_i,
  output logic                 open_o,
  output logic                 done_o,
  output logic [CNT_WIDTH-1:0] sig_cnt_o,
  output logic [CNT_WIDTH-1:0] ref_cnt_o
);

  logic [2:0] sync_q;
  logic       edge_q;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    return (c == '1) ? c : c + 1'b1;
  endfunction

  // Two metastability flops, one history flop, registered pulse: 3-cycle lag.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], sig_i};
      edge_q <= sync_q[1] & ~sync_q[2];
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      open_o    <= 1'b0;
      done_o    <= 1'b0;
      sig_cnt_o <= '0;
      ref_cnt_o <= '0;
    end else if (clr_i) begin
      open_o    <= 1'b0;
      done_o    <= 1'b0;
      sig_cnt_o <= '0;
      ref_cnt_o <= '0;
    end else if (gate_i) begin
      if (!open_o) begin
        if (edge_q) begin
          open_o    <= 1'b1;
          sig_cnt_o <= '0;
          ref_cnt_o <= '0;
        end
      end else begin
        ref_cnt_o <= sat_inc(ref_cnt_o);
        if (edge_q) sig_cnt_o <= sat_inc(sig_cnt_o);
      end
    end else if (wait_i && open_o) begin
      // The closing edge still counts, so the window spans whole periods.
      ref_cnt_o <= sat_inc(ref_cnt_o);
      if (edge_q) begin
        sig_cnt_o <= sat_inc(sig_cnt_o);
        open_o    <= 1'b0;
        done_o    <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/measure_mc.sv
// Multi-channel measurement top: gate/wait/dump sequencer, gate timer,
// timeout counter and registered result write port.
`timescale 1ns/1ps
module measure_mc
  import measure_pkg::*;
#(
  parameter int CH_NUM         = DEF_CH_NUM,
  parameter int CNT_WIDTH      = DEF_CNT_WIDTH,
  parameter int GATE_WIDTH     = DEF_GATE_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                                        clk_i,
  input  logic                                        rst_n_i,
  input  logic [CH_NUM-1:0]                           sig_clk_i,
  input  logic                                        gate_en_i,
  input  logic [GATE_WIDTH-1:0]                       gate_time_i,
  output logic                                        reg_wr_en_o,
  output logic [((CH_NUM > 1) ? $clog2(CH_NUM) : 1)-1:0] reg_wr_addr_o,
  output logic [2*CNT_WIDTH-1:0]                      reg_wr_data_o,
  output logic                                        gate_sync_o
);

  localparam int AW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

  state_t                             state, state_nxt;
  logic [GATE_WIDTH-1:0]              gate_tmr;
  logic [31:0]                        to_cnt;
  logic [AW-1:0]                      dump_idx;
  logic [CH_NUM-1:0]                  ch_open, ch_done;
  logic [CH_NUM-1:0][CNT_WIDTH-1:0]   sig_cnt, ref_cnt;
  logic                               abort, ch_clr, in_gate, in_wait;
  logic                               gate_end, to_hit, last_dump;

  assign in_gate   = (state == ST_GATE);
  assign in_wait   = (state == ST_WAIT);
  assign abort     = (in_gate || in_wait) && !gate_en_i;
  assign ch_clr    = (state == ST_IDLE) || abort;
  assign gate_end  = (gate_tmr == GATE_WIDTH'(1));
  assign to_hit    = (to_cnt == 32'(TIMEOUT_CYCLES - 1));
  assign last_dump = (dump_idx == AW'(CH_NUM - 1));
  assign gate_sync_o = |ch_open;

  for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
    measure_ch #(.CNT_WIDTH(CNT_WIDTH)) u_ch (
      .clk_i     (clk_i),
      .rst_n_i   (rst_n_i),
      .sig_i     (sig_clk_i[g]),
      .clr_i     (ch_clr),
      .gate_i    (in_gate),
      .wait_i    (in_wait),
      .open_o    (ch_open[g]),
      .done_o    (ch_done[g]),
      .sig_cnt_o (sig_cnt[g]),
      .ref_cnt_o (ref_cnt[g])
    );
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (gate_en_i) state_nxt = ST_GATE;
      ST_GATE: if (!gate_en_i) state_nxt = ST_IDLE;
               else if (gate_end) state_nxt = ST_WAIT;
      ST_WAIT: if (!gate_en_i) state_nxt = ST_IDLE;
               else if ((&ch_done) || to_hit) state_nxt = ST_DUMP;
      ST_DUMP: if (last_dump) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state         <= ST_IDLE;
      gate_tmr      <= '0;
      to_cnt        <= '0;
      dump_idx      <= '0;
      reg_wr_en_o   <= 1'b0;
      reg_wr_addr_o <= '0;
      reg_wr_data_o <= '0;
    end else begin
      state         <= state_nxt;
      reg_wr_en_o   <= 1'b0;
      reg_wr_addr_o <= '0;
      reg_wr_data_o <= '0;
      case (state)
        ST_IDLE: begin
          gate_tmr <= (gate_time_i == '0) ? GATE_WIDTH'(1) : gate_time_i;
          to_cnt   <= '0;
          dump_idx <= '0;
        end
        ST_GATE: gate_tmr <= gate_tmr - 1'b1;
        ST_WAIT: to_cnt <= to_cnt + 1'b1;
        ST_DUMP: begin
          // Channels that never closed their window report zero.
          reg_wr_en_o   <= 1'b1;
          reg_wr_addr_o <= dump_idx;
          reg_wr_data_o <= ch_done[dump_idx] ? {sig_cnt[dump_idx], ref_cnt[dump_idx]} : '0;
          dump_idx      <= dump_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_measure_mc.sv
// Directed bench for measure_mc: a 32-bit and an 8-bit counter instance share
// stimulus; a negedge monitor logs every write strobe of the 32-bit instance.
`timescale 1ns/1ps
module tb_measure_mc;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        gate_en;
  logic [31:0] gate_time;
  logic [3:0]  sig_clk;
  logic [3:0]  sig_en;

  logic        a_wr_en, a_sync, b_wr_en, b_sync;
  logic [1:0]  a_addr, b_addr;
  logic [63:0] a_data;
  logic [15:0] b_data;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int wr_n    = 0;
  int          wr_cyc  [128];
  logic [1:0]  wr_addr [128];
  logic [63:0] wr_data [128];
  logic [15:0] wrb_data[128];
  logic [1:0]  wrb_addr[128];

  always #2.5 clk = ~clk;

  measure_mc #(.CH_NUM(4), .CNT_WIDTH(32), .GATE_WIDTH(32), .TIMEOUT_CYCLES(500)) dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .sig_clk_i(sig_clk), .gate_en_i(gate_en),
    .gate_time_i(gate_time), .reg_wr_en_o(a_wr_en), .reg_wr_addr_o(a_addr),
    .reg_wr_data_o(a_data), .gate_sync_o(a_sync));

  measure_mc #(.CH_NUM(4), .CNT_WIDTH(8), .GATE_WIDTH(32), .TIMEOUT_CYCLES(500)) dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .sig_clk_i(sig_clk), .gate_en_i(gate_en),
    .gate_time_i(gate_time), .reg_wr_en_o(b_wr_en), .reg_wr_addr_o(b_addr),
    .reg_wr_data_o(b_data), .gate_sync_o(b_sync));

  // ch0..2: 1 MHz (200 clk per period), ch3: 500 kHz (400 clk per period).
  for (genvar g = 0; g < 4; g++) begin : g_sig
    localparam real HALF = (g == 3) ? 1000.0 : 500.0;
    logic s;
    assign sig_clk[g] = s;
    initial begin
      s = 1'b0;
      #(1.1 * (g + 1));
      forever begin
        #(HALF);
        s = sig_en[g] ? ~s : 1'b0;
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (a_wr_en) begin
      if (wr_n < 128) begin
        wr_cyc[wr_n]  <= cyc;
        wr_addr[wr_n] <= a_addr;
        wr_data[wr_n] <= a_data;
        wrb_data[wr_n] <= b_data;
        wrb_addr[wr_n] <= b_addr;
      end
      wr_n <= wr_n + 1;
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(negedge clk); #0.5; end
  endtask

  task automatic wait_wr(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #0.5;
      if (wr_n >= target) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; gate_en = 1'b0; gate_time = 32'd0; sig_en = 4'b1111;
    step(5);
    n_tests++; if (a_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en got %b want 0", a_wr_en); end
    n_tests++; if (a_addr !== 2'd0) begin n_fail++; $display("FAIL reset_addr got %0d want 0", a_addr); end
    n_tests++; if (a_data !== 64'd0) begin n_fail++; $display("FAIL reset_data got %h want 0", a_data); end
    n_tests++; if (a_sync !== 1'b0) begin n_fail++; $display("FAIL reset_sync got %b want 0", a_sync); end
    rst_n = 1'b1;
    step(50);
    n_tests++; if (wr_n !== 0) begin n_fail++; $display("FAIL idle_no_write got %0d want 0", wr_n); end
  endtask

  task automatic test_basic();
    int base; bit ok; logic [31:0] s0, r0, s1, r1, s3, r3;
    base = wr_n;
    gate_time = 32'd2000; gate_en = 1'b1;
    wait_wr(base + 1, 4000, ok);
    gate_en = 1'b0;  // drop during DUMP: burst must still complete
    n_tests++; if (!ok) begin n_fail++; $display("FAIL basic_first_write timed out got %0d writes want 1", wr_n - base); return; end
    wait_wr(base + 4, 10, ok);
    step(20);
    n_tests++; if (wr_n !== base + 4) begin n_fail++; $display("FAIL basic_count got %0d want 4", wr_n - base); return; end
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (wr_addr[base+k] !== 2'(k) || wr_cyc[base+k] !== wr_cyc[base] + k) begin
        n_fail++; $display("FAIL basic_addr_seq[%0d] got addr %0d cyc+%0d want addr %0d cyc+%0d",
                           k, wr_addr[base+k], wr_cyc[base+k] - wr_cyc[base], k, k);
      end
    end
    {s0, r0} = wr_data[base];
    {s1, r1} = wr_data[base+1];
    {s3, r3} = wr_data[base+3];
    n_tests++; if (s0 != 32'd10 && s0 != 32'd11) begin n_fail++; $display("FAIL basic_ch0_sig got %0d want 10 or 11", s0); end
    n_tests++; if (r0 !== s0 * 200) begin n_fail++; $display("FAIL basic_ch0_ref got %0d want %0d", r0, s0 * 200); end
    n_tests++; if (s1 == 0 || r1 !== s1 * 200) begin n_fail++; $display("FAIL basic_ch1 got sig %0d ref %0d want ref=200*sig", s1, r1); end
    n_tests++; if (s3 == 0 || r3 !== s3 * 400) begin n_fail++; $display("FAIL basic_ch3 got sig %0d ref %0d want ref=400*sig", s3, r3); end
  endtask

  task automatic test_timeout();
    int base; bit ok; logic [31:0] s1, r1;
    sig_en[2] = 1'b0;
    step(300);
    base = wr_n;
    gate_time = 32'd2000; gate_en = 1'b1;
    wait_wr(base + 1, 4000, ok);
    gate_en = 1'b0;
    n_tests++; if (!ok) begin n_fail++; $display("FAIL timeout_first_write timed out got %0d want 1", wr_n - base); sig_en[2] = 1'b1; return; end
    wait_wr(base + 4, 10, ok);
    step(10);
    sig_en[2] = 1'b1;
    n_tests++; if (wr_n !== base + 4) begin n_fail++; $display("FAIL timeout_count got %0d want 4", wr_n - base); return; end
    n_tests++; if (wr_addr[base+2] !== 2'd2 || wr_data[base+2] !== 64'd0) begin
      n_fail++; $display("FAIL timeout_ch2 got addr %0d data %h want addr 2 data 0", wr_addr[base+2], wr_data[base+2]); end
    n_tests++; if (wrb_data[base+2] !== 16'd0) begin n_fail++; $display("FAIL timeout_ch2_b got %h want 0", wrb_data[base+2]); end
    {s1, r1} = wr_data[base+1];
    n_tests++; if (s1 == 0 || r1 !== s1 * 200) begin n_fail++; $display("FAIL timeout_ch1 got sig %0d ref %0d want ref=200*sig", s1, r1); end
  endtask

  task automatic test_saturate();
    int base; bit ok; logic [31:0] s0, r0; logic [7:0] bs, br;
    base = wr_n;
    gate_time = 32'd1000; gate_en = 1'b1;
    wait_wr(base + 1, 3000, ok);
    gate_en = 1'b0;
    n_tests++; if (!ok) begin n_fail++; $display("FAIL sat_first_write timed out got %0d want 1", wr_n - base); return; end
    wait_wr(base + 4, 10, ok);
    step(10);
    {s0, r0} = wr_data[base];
    {bs, br} = wrb_data[base];
    n_tests++; if (br !== 8'hFF) begin n_fail++; $display("FAIL sat_ref got %h want ff", br); end
    n_tests++; if (bs != 8'd5 && bs != 8'd6) begin n_fail++; $display("FAIL sat_sig got %0d want 5 or 6", bs); end
    n_tests++; if (wrb_addr[base] !== 2'd0) begin n_fail++; $display("FAIL sat_addr got %0d want 0", wrb_addr[base]); end
    n_tests++; if (r0 !== s0 * 200 || s0[7:0] !== bs) begin n_fail++; $display("FAIL sat_wide_ch0 got sig %0d ref %0d want ref=200*sig sig=%0d", s0, r0, bs); end
  endtask

  task automatic test_abort();
    int base;
    base = wr_n;
    gate_time = 32'd2000; gate_en = 1'b1;
    step(101);  // IDLE cycle, then 100 GATE cycles
    gate_en = 1'b0;
    step(1);
    n_tests++; if (a_sync !== 1'b0 || b_sync !== 1'b0) begin n_fail++; $display("FAIL abort_sync got %b%b want 00", a_sync, b_sync); end
    step(3000);
    n_tests++; if (wr_n !== base) begin n_fail++; $display("FAIL abort_writes got %0d want 0", wr_n - base); end
  endtask

  task automatic test_back_to_back();
    int base; bit ok;
    base = wr_n;
    gate_time = 32'd300; gate_en = 1'b1;
    wait_wr(base + 9, 5000, ok);
    gate_en = 1'b0;
    n_tests++; if (!ok) begin n_fail++; $display("FAIL b2b_third_burst timed out got %0d writes want 9", wr_n - base); return; end
    wait_wr(base + 12, 10, ok);
    step(2000);
    n_tests++; if (wr_n !== base + 12) begin n_fail++; $display("FAIL b2b_count got %0d want 12", wr_n - base); return; end
    for (int b = 0; b < 3; b++) begin
      for (int k = 0; k < 4; k++) begin
        n_tests++;
        if (wr_addr[base+4*b+k] !== 2'(k) || wr_cyc[base+4*b+k] !== wr_cyc[base+4*b] + k) begin
          n_fail++; $display("FAIL b2b_burst%0d_slot%0d got addr %0d cyc+%0d want addr %0d cyc+%0d", b, k,
                             wr_addr[base+4*b+k], wr_cyc[base+4*b+k] - wr_cyc[base+4*b], k, k);
        end
      end
    end
    n_tests++; if (wr_cyc[base+4] - wr_cyc[base+3] <= 300) begin
      n_fail++; $display("FAIL b2b_gap got %0d want >300", wr_cyc[base+4] - wr_cyc[base+3]); end
  endtask

  task automatic test_reset_dump();
    int base, rel; bit ok;
    base = wr_n;
    gate_time = 32'd300; gate_en = 1'b1;
    wait_wr(base + 2, 3000, ok);
    n_tests++; if (!ok || wr_addr[base+1] !== 2'd1) begin n_fail++; $display("FAIL rstdump_addr1 got ok %0d addr %0d want addr 1", ok, wr_addr[base+1]); end
    rst_n = 1'b0;
    #0.5;
    n_tests++; if (a_wr_en !== 1'b0 || a_addr !== 2'd0 || a_data !== 64'd0 || a_sync !== 1'b0) begin
      n_fail++; $display("FAIL rstdump_outputs got en %b addr %0d data %h sync %b want all 0", a_wr_en, a_addr, a_data, a_sync); end
    step(3);
    n_tests++; if (wr_n !== base + 2) begin n_fail++; $display("FAIL rstdump_dropped got %0d writes want 2", wr_n - base); end
    rst_n = 1'b1;
    rel = cyc;
    wait_wr(base + 3, 3000, ok);
    gate_en = 1'b0;
    n_tests++; if (!ok) begin n_fail++; $display("FAIL rstdump_resume timed out got %0d want 3", wr_n - base); return; end
    n_tests++; if (wr_addr[base+2] !== 2'd0 || wr_cyc[base+2] - rel < 300) begin
      n_fail++; $display("FAIL rstdump_first_after got addr %0d after %0d cyc want addr 0 after >=300", wr_addr[base+2], wr_cyc[base+2] - rel); end
    wait_wr(base + 6, 10, ok);
    step(5);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_saturate();
    test_abort();
    test_back_to_back();
    test_reset_dump();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
